// File: rtl/result_unloader_pkg.sv
// Shared types and helpers for the result unloader.
// Holds the FSM state encoding and byte-counter sizing.
package result_unloader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RELEASE
  } state_t;

  localparam int BYTE_W = 8;

  // Width of a counter that indexes n bytes; never below one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/result_unloader_bit_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Stages only advance while the enable is high.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  // Shift the raw input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff <= '0;
    end else if (i_en) begin
      r_ff <= {r_ff[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/result_unloader.sv
// Streams a captured core result to the host a byte at a time.
// Optional ack timeout: define RESULT_UNLOADER_TIMEOUT_EN.
module result_unloader
  import result_unloader_pkg::*;
#(
  parameter int NUM_BYTES      = 4,
  parameter int MSB_FIRST      = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [BYTE_W*NUM_BYTES-1:0] result,
  input  logic                        result_valid,
  output logic                        result_ready,
  input  logic                        host_ack,
  output logic [BYTE_W-1:0]           out_pins,
  output logic                        out_strobe,
  output logic                        busy
`ifdef RESULT_UNLOADER_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int RW = BYTE_W * NUM_BYTES;
  localparam int CW = cnt_width(NUM_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  state_t              r_state;
  state_t              w_state_n;
  logic [RW-1:0]       r_shift;
  logic [RW-1:0]       w_shift_n;
  logic [RW-1:0]       w_shifted;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_n;
  logic [BYTE_W-1:0]   r_pins;
  logic [BYTE_W-1:0]   w_pins_n;
  logic                r_strobe;
  logic                w_strobe_n;
  logic                w_ack_s;

  function automatic logic [BYTE_W-1:0] head(
    input logic [RW-1:0] v
  );
    if (MSB_FIRST != 0) return v[RW-1 -: BYTE_W];
    return v[BYTE_W-1:0];
  endfunction

  function automatic logic [RW-1:0] advance(
    input logic [RW-1:0] v
  );
    if (MSB_FIRST != 0) return v << BYTE_W;
    return v >> BYTE_W;
  endfunction

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst  (rst),
    .i_en (ena),
    .i_d  (host_ack),
    .o_q  (w_ack_s)
  );

  assign w_shifted = advance(r_shift);

`ifdef RESULT_UNLOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_wait;
  logic [TW-1:0] w_wait_n;
  logic          r_err;
  logic          w_err_n;
`endif

  // Next-state and next-output decode for the byte handshake.
  always_comb begin
    w_state_n  = r_state;
    w_shift_n  = r_shift;
    w_cnt_n    = r_cnt;
    w_pins_n   = r_pins;
    w_strobe_n = r_strobe;
`ifdef RESULT_UNLOADER_TIMEOUT_EN
    w_wait_n   = '0;
    w_err_n    = r_err;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_strobe_n = 1'b0;
        if (result_valid) begin
          w_shift_n  = result;
          w_cnt_n    = '0;
          w_pins_n   = head(result);
          w_strobe_n = 1'b1;
          w_state_n  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (w_ack_s) begin
          w_strobe_n = 1'b0;
          w_state_n  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!w_ack_s) begin
          if (r_cnt == LAST) begin
            w_state_n = S_IDLE;
          end else begin
            w_cnt_n    = r_cnt + 1'b1;
            w_shift_n  = w_shifted;
            w_pins_n   = head(w_shifted);
            w_strobe_n = 1'b1;
            w_state_n  = S_DRIVE;
          end
        end
      end
      default: begin
        w_strobe_n = 1'b0;
        w_state_n  = S_IDLE;
      end
    endcase
`ifdef RESULT_UNLOADER_TIMEOUT_EN
    // A state change restarts the wait; staying put counts up.
    if (r_state != S_IDLE && w_state_n == r_state) begin
      if (r_wait == WAIT_LAST) begin
        w_state_n  = S_IDLE;
        w_strobe_n = 1'b0;
        w_err_n    = 1'b1;
      end else begin
        w_wait_n = r_wait + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers; ena low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_pins   <= '0;
      r_strobe <= 1'b0;
    end else if (ena) begin
      r_state  <= w_state_n;
      r_shift  <= w_shift_n;
      r_cnt    <= w_cnt_n;
      r_pins   <= w_pins_n;
      r_strobe <= w_strobe_n;
    end
  end

`ifdef RESULT_UNLOADER_TIMEOUT_EN
  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else if (ena) begin
      r_wait <= w_wait_n;
      r_err  <= w_err_n;
    end
  end

  assign timeout_err = r_err;
`endif

  assign result_ready = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign out_pins     = r_pins;
  assign out_strobe   = r_strobe;

endmodule

// File: tb/tb_result_unloader.sv
// Randomised bench for result_unloader: LSB- and MSB-first
// instances share stimulus; expected bytes come from arithmetic.
module tb_result_unloader;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        host_ack;
  logic        result_valid;
  logic [31:0] result;

  logic        rdy_l, stb_l, busy_l;
  logic [7:0]  pins_l;
  logic        rdy_m, stb_m, busy_m;
  logic [7:0]  pins_m;
`ifdef RESULT_UNLOADER_TIMEOUT_EN
  logic        err_l, err_m;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_unloader #(
    .NUM_BYTES      (NB),
    .MSB_FIRST      (0),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) u_lsb (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (rdy_l),
    .host_ack     (host_ack),
    .out_pins     (pins_l),
    .out_strobe   (stb_l),
    .busy         (busy_l)
`ifdef RESULT_UNLOADER_TIMEOUT_EN
    ,
    .timeout_err  (err_l)
`endif
  );

  result_unloader #(
    .NUM_BYTES      (NB),
    .MSB_FIRST      (1),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) u_msb (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (rdy_m),
    .host_ack     (host_ack),
    .out_pins     (pins_m),
    .out_strobe   (stb_m),
    .busy         (busy_m)
`ifdef RESULT_UNLOADER_TIMEOUT_EN
    ,
    .timeout_err  (err_m)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Byte idx of the wire sequence for value v.
  function automatic logic [7:0] exp_byte(
    input logic [31:0] v,
    input int          idx,
    input bit          msb
  );
    int sh;
    sh = msb ? (NB - 1 - idx) : idx;
    return 8'((v >> (8 * sh)) & 32'hFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete result transfer acting as core and host.
  task automatic xfer(
    input logic [31:0] v,
    input int          abort_at,
    input bit          bp,
    input logic [31:0] bpv,
    input int          frz_at
  );
    result       = v;
    result_valid = 1'b1;
    chk("rdy_pre", rdy_l, 1);
    tick();
    result_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      chk("stb_on", stb_l, 1);
      chk("stb_m_on", stb_m, 1);
      chk("pins_l", pins_l, exp_byte(v, i, 0));
      chk("pins_m", pins_m, exp_byte(v, i, 1));
      chk("busy", busy_l, 1);
      chk("rdy_busy", rdy_l, 0);
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_stb", stb_l, 0);
        chk("rst_pins", pins_l, 0);
        chk("rst_pins_m", pins_m, 0);
        chk("rst_busy", busy_l, 0);
        chk("rst_rdy", rdy_l, 1);
        return;
      end
      if (bp && i == NB / 2) begin
        result       = bpv;
        result_valid = 1'b1;
      end
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("hold_stb", stb_l, 1);
        chk("hold_pins", pins_l, exp_byte(v, i, 0));
      end
      host_ack = 1'b1;
      if (i == frz_at) begin
        ena = 1'b0;
        repeat (5) begin
          tick();
          chk("frz_stb", stb_l, 1);
          chk("frz_pins", pins_l, exp_byte(v, i, 0));
          chk("frz_busy", busy_l, 1);
        end
        ena = 1'b1;
      end
      tick();
      tick();
      chk("lat_rise_hi", stb_l, 1);
      tick();
      chk("lat_rise_lo", stb_l, 0);
      chk("rel_pins", pins_l, exp_byte(v, i, 0));
      chk("rel_rdy", rdy_l, 0);
      repeat ($urandom_range(0, 4)) begin
        tick();
        chk("ackhi_stb", stb_l, 0);
        chk("ackhi_pins", pins_l, exp_byte(v, i, 0));
      end
      host_ack = 1'b0;
      tick();
      tick();
      chk("lat_fall_lo", stb_l, 0);
      tick();
      if (i == NB - 1) begin
        chk("done_busy", busy_l, 0);
        chk("done_rdy", rdy_l, 1);
        chk("done_stb", stb_l, 0);
        chk("done_busy_m", busy_m, 0);
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] bpv;
    bit          pend;
    bit          bp;
    int          ab;
    int          fz;

    rst          = 1'b1;
    ena          = 1'b1;
    host_ack     = 1'b0;
    result_valid = 1'b0;
    result       = '0;
    tick();
    tick();
    chk("reset_pins", pins_l, 0);
    chk("reset_stb", stb_l, 0);
    chk("reset_busy", busy_l, 0);
    rst = 1'b0;
    tick();
    chk("reset_rdy", rdy_l, 1);
    chk("reset_busy2", busy_l, 0);

    xfer(32'h12345678, -1, 1'b0, 32'h0, -1);
    xfer(32'hDEADBEEF, -1, 1'b1, 32'hCAFEF00D, 1);
    xfer(32'hCAFEF00D, -1, 1'b0, 32'h0, -1);
    xfer(32'h0BADF00D, 2, 1'b0, 32'h0, -1);
    xfer(32'h89ABCDEF, -1, 1'b0, 32'h0, -1);

    // No capture while disabled.
    ena          = 1'b0;
    result       = 32'h55AA33CC;
    result_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("ena0_busy", busy_l, 0);
      chk("ena0_stb", stb_l, 0);
    end
    ena = 1'b1;
    xfer(32'h55AA33CC, -1, 1'b0, 32'h0, -1);

    pend = 1'b0;
    bpv  = '0;
    for (int n = 0; n < 24; n++) begin
      v    = pend ? bpv : $urandom;
      bp   = ($urandom_range(0, 3) == 0);
      bpv  = $urandom;
      ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      fz   = int'($urandom_range(0, 5));
      xfer(v, ab, bp, bpv, fz);
      pend = bp && (ab < 0 || ab > NB / 2);
    end
    result_valid = 1'b0;

`ifdef RESULT_UNLOADER_TIMEOUT_EN
    tick();
    result       = 32'h13572468;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    repeat (15) begin
      tick();
      chk("to_busy", busy_l, 1);
    end
    tick();
    chk("to_idle", busy_l, 0);
    chk("to_stb", stb_l, 0);
    chk("to_err", err_l, 1);
    repeat (4) tick();
    chk("to_sticky", err_l, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_clr", err_l, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Return-path counterpart of the parameter loader.
- Accepts one signed 32-bit result from the compute core via a valid/ready handshake.
- Streams the result to the host over 8 output pins, one byte at a time, using a 4-phase strobe/ack handshake.
- Sits between the core's result port and the chip output pins; host ack enters on an input pin.

Parameters:
- NUM_BYTES, 4: bytes per result; result width = 8*NUM_BYTES.
- MSB_FIRST, 0: 0 = least-significant byte sent first; 1 = most-significant byte first.
- SYNC_STAGES, 2: flops in the host_ack synchroniser; minimum 2.
- TIMEOUT_CYCLES, 1023: ack wait limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; low freezes all state.
- result  in  8*NUM_BYTES  signed result from core.
- result_valid  in  1  core holds result stable while high.
- result_ready  out  1  high in S_IDLE; capture occurs when valid && ready && ena.
- host_ack  in  1  asynchronous host acknowledge pin.
- out_pins  out  8  current byte.
- out_strobe  out  1  byte valid to host.
- busy  out  1  high whenever state != S_IDLE.
- timeout_err  out  1  sticky error flag; present only with the optional feature.

Behaviour:
- Reset values:
  - state = S_IDLE; out_pins = 0; out_strobe = 0; busy = 0; shift register = 0; byte counter = 0; sync flops = 0; timeout_err = 0.
  - result_ready = 1 the cycle after reset releases.
- Reset is synchronous: rst sampled high at a clk edge aborts any transfer in progress. The partially sent result is discarded and strobe drops at that edge.
- ena = 0: no state, counter, shift or sync update; all outputs hold their values.
- host_ack passes through SYNC_STAGES flops; ack_s is the last stage. All decisions use ack_s only.
- States:
  - S_IDLE:
    - result_ready = 1; out_strobe = 0.
    - On valid && ena: latch result into the shift register, clear the byte counter, go to S_DRIVE.
    - At that same edge, out_pins <= first byte and out_strobe <= 1.
  - S_DRIVE:
    - out_strobe = 1; out_pins stable.
    - When ack_s = 1: out_strobe <= 0, go to S_RELEASE.
  - S_RELEASE:
    - out_strobe = 0; out_pins keep the last byte.
    - When ack_s = 0:
      - if counter == NUM_BYTES-1: go to S_IDLE;
      - else: counter++, shift by 8 in the send direction, out_pins <= next byte, out_strobe <= 1, go to S_DRIVE.
- Latency:
  - Capture edge to first strobe: 0 cycles (strobe is visible in the next cycle).
  - Raw ack rise to strobe fall: SYNC_STAGES+1 edges.
  - Same for ack fall to the next strobe rise.
- Result arriving while busy: result_ready = 0, so nothing is captured and the core must hold the result. A new result is accepted in the first S_IDLE cycle.
- ack already high on entry to S_DRIVE: the block waits for ack_s = 1, which is satisfied immediately. S_RELEASE then blocks until ack falls, so no byte is skipped.
- Signedness: bytes are raw two's-complement slices; no sign processing.

Optional Feature:
- Macro: RESULT_UNLOADER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every entry to S_DRIVE or S_RELEASE and increments each enabled cycle spent in either state.
  - Reaching TIMEOUT_CYCLES forces state to S_IDLE, out_strobe to 0, and sets timeout_err = 1.
  - timeout_err stays set until rst.
- Undefined:
  - No counter and no timeout_err port; the block waits indefinitely.

Decomposition:
- Package result_unloader_pkg:
  - state enum (S_IDLE, S_DRIVE, S_RELEASE);
  - byte-width localparam (8);
  - a function to compute the byte-counter width from NUM_BYTES.
- One sub-module: bit_sync, a parameterised SYNC_STAGES flop chain with synchronous active-high reset, used for host_ack.

Test Plan:
- LSB-first order:
  - Stimulus: reset, ena = 1, result = 0x12345678, valid pulse, host acks each strobe after 3 cycles.
  - Required: out_pins sequence 0x78, 0x56, 0x34, 0x12; busy falls after the 4th ack release; result_ready returns to 1.
- MSB-first order:
  - Stimulus: MSB_FIRST = 1, result = 0xDEADBEEF (negative value).
  - Required: out_pins sequence 0xDE, 0xAD, 0xBE, 0xEF.
- Backpressure and hold:
  - Stimulus: second valid with 0xCAFEF00D asserted mid-transfer; ena low for 5 cycles during S_DRIVE.
  - Required: second result captured only after return to S_IDLE; out_pins and out_strobe frozen while ena = 0.
- Reset mid-transfer:
  - Stimulus: rst high while byte 2 is strobed.
  - Required: next cycle out_strobe = 0, out_pins = 0, busy = 0, result_ready = 1; a fresh result starts again from byte 0.
- Synchroniser latency:
  - Stimulus: host_ack raised at cycle N, SYNC_STAGES = 2.
  - Required: out_strobe low at cycle N+3 exactly; ack held high does not advance more than one byte.
- Timeout (RESULT_UNLOADER_TIMEOUT_EN, TIMEOUT_CYCLES = 16):
  - Stimulus: send a result, never ack.
  - Required: after 16 cycles in S_DRIVE, state = S_IDLE, timeout_err = 1 and stays set until rst.
